// File: rtl/ldpc_pkg.sv
// Shared LDPC constants, H-ROM field layout and checker FSM state type.
// Imported by the syndrome checker and by the variable/check node units.
package ldpc_pkg;

    localparam int N_VAR  = 100;
    localparam int N_CHK  = 80;
    localparam int ROW_WT = 5;
    localparam int COL_WT = 4;
    localparam int IDX_W  = 8;

    localparam int ROM_AW = 7;
    localparam int ROM_W  = 72;

    localparam int COLP_LSB = 0;
    localparam int COLP_MSB = 39;
    localparam int ROWP_LSB = 40;
    localparam int ROWP_MSB = 71;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_REPORT
    } state_e;

endpackage

// File: rtl/ldpc_row_parity.sv
// Parity of one check row over the hard-decision word.
// Out-of-range column indices contribute nothing and flag an error.
module ldpc_row_parity
    import ldpc_pkg::*;
(
    input  logic [N_VAR-1:0]        word_i,
    input  logic [ROW_WT*IDX_W-1:0] cols_i,
    output logic                    parity_o,
    output logic                    idx_err_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        parity_o  = 1'b0;
        idx_err_o = 1'b0;
        idx       = '0;
        for (int j = 0; j < ROW_WT; j++) begin
            idx = cols_i[(ROW_WT - j) * IDX_W - 1 -: IDX_W];
            if (idx >= IDX_W'(N_VAR))
                idx_err_o = 1'b1;
            else
                parity_o = parity_o ^ word_i[idx[6:0]];
        end
    end

endmodule

// File: rtl/positionsrowcol.sv
// H-position ROM, 1-cycle read latency. Address a < 80: column indices of
// check a in [39:0]; address a < 100: check rows of variable a in [71:40].
module positionsrowcol
    import ldpc_pkg::*;
(
    input  logic              clka,
    input  logic              wea,
    input  logic [ROM_AW-1:0] addra,
    input  logic [ROM_W-1:0]  dina,
    output logic [ROM_W-1:0]  douta
);

    logic unused_wr;
    assign unused_wr = ^{wea, dina};

    // Four groups of 20 checks, each group covering every column once.
    function automatic logic [ROM_W-1:0] rom_word(input logic [ROM_AW-1:0] a);
        logic [ROM_W-1:0] w;
        int r, g, i, c;
        int rw [COL_WT];
        w = '0;
        r = int'(a);
        g = r / 20;
        i = r % 20;
        if (r < N_CHK) begin
            for (int j = 0; j < ROW_WT; j++) begin
                if (g == 0)
                    c = 5 * i + j;
                else if (g == 1)
                    c = i + 20 * j;
                else if (g == 2)
                    c = (5 * i + j + 37) % 100;
                else
                    c = (i + 20 * j + 13) % 100;
                w[COLP_MSB - IDX_W * j -: IDX_W] = IDX_W'(c);
            end
        end
        if (r < N_VAR) begin
            rw[0] = r / 5;
            rw[1] = 20 + r % 20;
            rw[2] = 40 + ((r + 63) % 100) / 5;
            rw[3] = 60 + ((r + 87) % 100) % 20;
            for (int k = 0; k < COL_WT; k++)
                w[ROWP_MSB - IDX_W * k -: IDX_W] = IDX_W'(rw[k]);
        end
        return w;
    endfunction

    always_ff @(posedge clka) begin
        douta <= rom_word(addra);
    end

endmodule

// File: rtl/ldpc_syndrome_check.sv
// Sequential syndrome checker: one H row per cycle, then a stop /
// iterate / give-up decision for the decoder controller.
module ldpc_syndrome_check
    import ldpc_pkg::*;
#(
    parameter logic [7:0] MAX_ITER   = 8'd50,
    parameter logic       EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_VAR-1:0] decision,
    input  logic [7:0]       iteration_num,
    output logic             busy,
    output logic             done,
    output logic             syndrome_zero,
    output logic [6:0]       unsat_count,
    output logic             next_iter,
    output logic             give_up,
    output logic [N_VAR-1:0] key_out,
    output logic             rom_err
);

    state_e            state_q;
    logic [ROM_AW-1:0] row_q;
    logic              vld_q;
    logic [7:0]        iter_q;
    logic [6:0]        unsat_q;
    logic [N_VAR-1:0]  key_q;
    logic              busy_q, done_q, sz_q, next_q, gu_q, rom_err_q;

    logic [ROM_W-1:0]  rom_dout;
    logic              parity, idx_err;
    logic              hit, abort;
    logic [6:0]        unsat_d;
    logic              sz_d, gu_d;

    positionsrowcol u_rom (
        .clka  (clk),
        .wea   (1'b0),
        .addra (row_q),
        .dina  ('0),
        .douta (rom_dout)
    );

    logic unused_rowp;
    assign unused_rowp = ^rom_dout[ROWP_MSB:ROWP_LSB];

    ldpc_row_parity u_par (
        .word_i    (key_q),
        .cols_i    (rom_dout[COLP_MSB:COLP_LSB]),
        .parity_o  (parity),
        .idx_err_o (idx_err)
    );

    // vld_q marks a cycle whose ROM output belongs to the current scan.
    always_comb begin
        hit     = vld_q & parity;
        abort   = EARLY_EXIT && hit && (state_q == S_SCAN);
        unsat_d = unsat_q;
        if (hit && (unsat_q < 7'(N_CHK)))
            unsat_d = unsat_q + 7'd1;
        sz_d = (unsat_d == 7'd0);
        gu_d = !sz_d && (({1'b0, iter_q} + 9'd1) >= {1'b0, MAX_ITER});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            vld_q     <= 1'b0;
            iter_q    <= '0;
            unsat_q   <= '0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sz_q      <= 1'b0;
            next_q    <= 1'b0;
            gu_q      <= 1'b0;
            rom_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            next_q <= 1'b0;
            gu_q   <= 1'b0;
            vld_q  <= (state_q == S_SCAN) && !abort;
            if (vld_q) begin
                unsat_q <= unsat_d;
                if (idx_err)
                    rom_err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_q   <= decision;
                        iter_q  <= iteration_num;
                        unsat_q <= '0;
                        sz_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort || row_q == ROM_AW'(N_CHK - 1)) begin
                        row_q   <= '0;
                        state_q <= abort ? S_REPORT : S_FLUSH;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                    if (abort) begin
                        done_q <= 1'b1;
                        sz_q   <= sz_d;
                        gu_q   <= gu_d;
                        next_q <= !sz_d && !gu_d;
                        busy_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    done_q  <= 1'b1;
                    sz_q    <= sz_d;
                    gu_q    <= gu_d;
                    next_q  <= !sz_d && !gu_d;
                    busy_q  <= 1'b0;
                    state_q <= S_REPORT;
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign syndrome_zero = sz_q;
    assign unsat_count   = unsat_q;
    assign next_iter     = next_q;
    assign give_up       = gu_q;
    assign key_out       = key_q;
    assign rom_err       = rom_err_q;

endmodule

// File: tb/tb_ldpc_syndrome_check.sv
// Directed bench for ldpc_syndrome_check: full scans, iteration limit,
// early exit, busy-start rejection, mid-scan reset and back-to-back starts.
module tb_ldpc_syndrome_check;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [99:0]  decision = '0;
    logic [7:0]   iteration_num = '0;
    logic         busy, done, syndrome_zero, next_iter, give_up, rom_err;
    logic [6:0]   unsat_count;
    logic [99:0]  key_out;

    logic         start_e = 1'b0;
    logic [99:0]  dec_e = '0;
    logic [7:0]   it_e = '0;
    logic         busy_e, done_e, sz_e, next_e, gu_e, rom_err_e;
    logic [6:0]   unsat_e;
    logic [99:0]  key_e;

    int checks = 0;
    int failures = 0;

    localparam logic [99:0] ZERO = '0;
    localparam logic [99:0] ONES = '1;
    localparam logic [99:0] BIT0 = 100'd1;

    always #5 clk = ~clk;

    ldpc_syndrome_check dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .decision      (decision),
        .iteration_num (iteration_num),
        .busy          (busy),
        .done          (done),
        .syndrome_zero (syndrome_zero),
        .unsat_count   (unsat_count),
        .next_iter     (next_iter),
        .give_up       (give_up),
        .key_out       (key_out),
        .rom_err       (rom_err)
    );

    ldpc_syndrome_check #(.EARLY_EXIT(1'b1)) dut_ee (
        .clk           (clk),
        .rst           (rst),
        .start         (start_e),
        .decision      (dec_e),
        .iteration_num (it_e),
        .busy          (busy_e),
        .done          (done_e),
        .syndrome_zero (sz_e),
        .unsat_count   (unsat_e),
        .next_iter     (next_e),
        .give_up       (gu_e),
        .key_out       (key_e),
        .rom_err       (rom_err_e)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a scan on the main DUT; lat = cycle index of done (start = 0).
    task automatic run(input logic [99:0] d, input logic [7:0] it,
                       output int lat);
        @(negedge clk);
        decision      = d;
        iteration_num = it;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_result(input string tag, input int lat,
                                 input logic sz, input logic [6:0] uc,
                                 input logic nx, input logic gu,
                                 input logic [99:0] key);
        check({tag, "_lat"}, 128'(lat), 128'd82);
        check({tag, "_sz"}, 128'(syndrome_zero), 128'(sz));
        check({tag, "_unsat"}, 128'(unsat_count), 128'(uc));
        check({tag, "_next"}, 128'(next_iter), 128'(nx));
        check({tag, "_giveup"}, 128'(give_up), 128'(gu));
        check({tag, "_key"}, 128'(key_out), 128'(key));
    endtask

    initial begin
        int lat;
        int ndone;

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_sz", 128'(syndrome_zero), 128'd0);
        check("rst_unsat", 128'(unsat_count), 128'd0);
        check("rst_next", 128'(next_iter), 128'd0);
        check("rst_giveup", 128'(give_up), 128'd0);
        check("rst_key", 128'(key_out), 128'd0);
        check("rst_romerr", 128'(rom_err), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        run(ZERO, 8'd0, lat);
        expect_result("zero_it0", lat, 1'b1, 7'd0, 1'b0, 1'b0, ZERO);
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'd0);
        check("sz_hold", 128'(syndrome_zero), 128'd1);

        run(BIT0, 8'd3, lat);
        expect_result("bit0_it3", lat, 1'b0, 7'd4, 1'b1, 1'b0, BIT0);

        run(BIT0, 8'd49, lat);
        expect_result("bit0_it49", lat, 1'b0, 7'd4, 1'b0, 1'b1, BIT0);

        run(ZERO, 8'd49, lat);
        expect_result("zero_it49", lat, 1'b1, 7'd0, 1'b0, 1'b0, ZERO);

        // Back-to-back: second start lands in cycle 83 of the first scan.
        run(ONES, 8'd0, lat);
        expect_result("b2b_a_ones", lat, 1'b0, 7'd80, 1'b1, 1'b0, ONES);
        run(ZERO, 8'd10, lat);
        expect_result("b2b_b_zero", lat, 1'b1, 7'd0, 1'b0, 1'b0, ZERO);

        // Early exit: bit 0 is in check row 0, so done lands in cycle 3.
        @(negedge clk);
        dec_e   = BIT0;
        it_e    = 8'd0;
        start_e = 1'b1;
        @(negedge clk);
        check("ee_busy", 128'(busy_e), 128'd1);
        dec_e   = ONES;
        start_e = 1'b1;
        lat     = 1;
        while (!done_e && lat < 200) begin
            @(negedge clk);
            start_e = 1'b0;
            lat++;
        end
        start_e = 1'b0;
        check("ee_lat", 128'(lat), 128'd3);
        check("ee_unsat", 128'(unsat_e), 128'd1);
        check("ee_key", 128'(key_e), 128'(BIT0));
        check("ee_next", 128'(next_e), 128'd1);
        check("ee_sz", 128'(sz_e), 128'd0);
        check("ee_giveup", 128'(gu_e), 128'd0);
        @(negedge clk);
        check("ee_busy_after", 128'(busy_e), 128'd0);

        // Reset in cycle 40 of a scan.
        @(negedge clk);
        decision      = ONES;
        iteration_num = 8'd1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_busy_before", 128'(busy), 128'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_busy_rst", 128'(busy), 128'd0);
        check("mid_key_rst", 128'(key_out), 128'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_no_done", 128'(ndone), 128'd0);
        run(BIT0, 8'd3, lat);
        expect_result("after_rst", lat, 1'b0, 7'd4, 1'b1, 1'b0, BIT0);

        check("romerr_end", 128'(rom_err), 128'd0);
        check("romerr_ee_end", 128'(rom_err_e), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
